// File: rtl/ofs_asp_irq_ctrl.sv
// ofs_asp_irq_ctrl: captures ASP IRQ edges into sticky pending bits, exposes MASK/STATUS/CLEAR/RAW CSRs,
// and forwards unmasked lines round-robin to the host-channel interrupt port with a ready/ack handshake.
module ofs_asp_irq_ctrl #(
  parameter int NUM_LINES = 4,
  parameter int NUM_USED = 3,
  parameter int MMIO_DATA_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 5,
  parameter int ACK_TIMEOUT = 1023,
  localparam int ID_W = $clog2(NUM_LINES),
  localparam int TW = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_LINES-1:0]         irq_src,
  input  logic [CSR_ADDR_WIDTH-1:0]    csr_address,
  input  logic                         csr_read,
  input  logic                         csr_write,
  input  logic [MMIO_DATA_WIDTH-1:0]   csr_writedata,
  input  logic [MMIO_DATA_WIDTH/8-1:0] csr_byteenable,
  output logic [MMIO_DATA_WIDTH-1:0]   csr_readdata,
  output logic                         csr_readdatavalid,
  output logic                         csr_waitrequest,
  output logic                         irq_valid,
  output logic [ID_W-1:0]              irq_id,
  input  logic                         irq_ready,
  input  logic                         irq_ack,
  input  logic [ID_W-1:0]              irq_ack_id
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;
  localparam logic [NUM_LINES-1:0] USED = NUM_LINES'((1 << NUM_USED) - 1);
  state_t state, state_nxt;
  logic [NUM_LINES-1:0] pending, mask, sent, src_q, edges, clr, set, eligible, rd_val;
  logic [ID_W-1:0] rr_ptr, rr_nxt, pick, id_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic valid_nxt, wr_en, unused_ok;
  assign edges = irq_src & ~src_q & USED;
  assign wr_en = csr_write & csr_byteenable[0];
  assign clr = (wr_en && csr_address == CSR_ADDR_WIDTH'(16)) ? csr_writedata[NUM_LINES-1:0] & USED : '0;
  assign eligible = pending & mask & ~sent;
  assign csr_waitrequest = 1'b0;
  assign rd_val = csr_address == CSR_ADDR_WIDTH'(0)  ? pending :
                  csr_address == CSR_ADDR_WIDTH'(8)  ? mask :
                  csr_address == CSR_ADDR_WIDTH'(24) ? irq_src : '0;
  assign unused_ok = ^{csr_writedata[MMIO_DATA_WIDTH-1:NUM_LINES], csr_byteenable[MMIO_DATA_WIDTH/8-1:1]};
  // Scan downward so the lowest offset from rr_ptr is the final winner.
  always_comb begin
    pick = rr_ptr;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (eligible[ID_W'((int'(rr_ptr) + i) % NUM_LINES)]) pick = ID_W'((int'(rr_ptr) + i) % NUM_LINES);
  end
  always_comb begin
    state_nxt = state;
    valid_nxt = irq_valid;
    id_nxt = irq_id;
    rr_nxt = rr_ptr;
    timer_nxt = timer;
    set = '0;
    case (state)
      IDLE: if (|eligible) begin
        state_nxt = SEND;
        valid_nxt = 1'b1;
        id_nxt = pick;
        rr_nxt = ID_W'((int'(pick) + 1) % NUM_LINES);
      end
      SEND: if (irq_ready) begin
        state_nxt = WAIT_ACK;
        valid_nxt = 1'b0;
        timer_nxt = '0;
      end
      WAIT_ACK: if (irq_ack && irq_ack_id == irq_id) begin
        set[irq_id] = 1'b1;
        state_nxt = IDLE;
      end else if (timer == TW'(ACK_TIMEOUT)) state_nxt = IDLE;
      else timer_nxt = timer + TW'(1);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      mask <= '0;
      sent <= '0;
      src_q <= '0;
      rr_ptr <= '0;
      timer <= '0;
      irq_valid <= 1'b0;
      irq_id <= '0;
      csr_readdata <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      src_q <= irq_src;
      pending <= (pending & ~clr) | edges;
      sent <= (sent & ~clr) | set;
      if (wr_en && csr_address == CSR_ADDR_WIDTH'(8)) mask <= csr_writedata[NUM_LINES-1:0] & USED;
      rr_ptr <= rr_nxt;
      timer <= timer_nxt;
      irq_valid <= valid_nxt;
      irq_id <= id_nxt;
      csr_readdata <= csr_read ? MMIO_DATA_WIDTH'(rd_val) : '0;
      csr_readdatavalid <= csr_read;
    end
endmodule
